// File: rtl/gpr_transfer_sequencer.sv
// gpr_transfer_sequencer: sequences transfers within the four-register GPR group (A-D).
//   clk, rst         : clock and synchronous active-high reset
//   req_valid/ready  : request handshake; ready is high only in IDLE
//   req_op           : 00 NOP, 01 MOV, 10 ALU, 11 LDX
//   req_src/lhs/rhs  : MOV source, ALU LHS operand, ALU RHS operand
//   req_dst          : destination register for MOV/ALU/LDX
//   gpr_load         : one-hot load strobe, bit0 = A
//   gpr_main_n       : per-register main-bus assert, active low
//   gpr_lhs_n/rhs_n  : per-register ALU operand bus assert, active low
//   alu_main_oe      : ALU result drives the main bus
//   ext_gnt          : external source owns the main bus
//   busy             : inverse of req_ready
module gpr_transfer_sequencer #(
    parameter int ALU_SETTLE = 1,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [1:0] req_src,
    input  logic [1:0] req_lhs,
    input  logic [1:0] req_rhs,
    input  logic [1:0] req_dst,
    output logic [3:0] gpr_load,
    output logic [3:0] gpr_main_n,
    output logic [3:0] gpr_lhs_n,
    output logic [3:0] gpr_rhs_n,
    output logic       alu_main_oe,
    output logic       ext_gnt,
    output logic       busy
);
    typedef enum logic [2:0] {
        IDLE, MOV_DRIVE, MOV_LOAD, ALU_OPS, ALU_DRIVE, ALU_LOAD, X_DRIVE, X_LOAD
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       src_q, src_d, lhs_q, lhs_d, rhs_q, rhs_d, dst_q, dst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d, busy_q, busy_d, oe_q, oe_d, gnt_q, gnt_d;
    logic [3:0]       load_q, load_d, main_q, main_d, lhsn_q, lhsn_d, rhsn_q, rhsn_d;
    logic             accept, alu_st;

    function automatic logic [3:0] oh(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    assign accept = req_valid && ready_q;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        lhs_d   = lhs_q;
        rhs_d   = rhs_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    src_d = req_src;
                    lhs_d = req_lhs;
                    rhs_d = req_rhs;
                    dst_d = req_dst;
                    case (req_op)
                        2'b01:   state_d = (req_src != req_dst) ? MOV_DRIVE : IDLE;
                        2'b10: begin
                            state_d = ALU_OPS;
                            cnt_d   = CNT_W'(ALU_SETTLE - 1);
                        end
                        2'b11:   state_d = X_DRIVE;
                        default: state_d = IDLE;
                    endcase
                end
            end
            MOV_DRIVE: state_d = MOV_LOAD;
            ALU_OPS: begin
                if (cnt_q == '0) state_d = ALU_DRIVE;
                else cnt_d = cnt_q - 1'b1;
            end
            ALU_DRIVE: state_d = ALU_LOAD;
            X_DRIVE:   state_d = X_LOAD;
            default:   state_d = IDLE;
        endcase
        // Outputs are a registered decode of the next state so they line up with state_q.
        alu_st  = (state_d == ALU_OPS) || (state_d == ALU_DRIVE) || (state_d == ALU_LOAD);
        ready_d = state_d == IDLE;
        busy_d  = state_d != IDLE;
        load_d  = (state_d == MOV_LOAD || state_d == ALU_LOAD || state_d == X_LOAD) ? oh(dst_d) : 4'b0000;
        main_d  = (state_d == MOV_DRIVE || state_d == MOV_LOAD) ? ~oh(src_d) : 4'b1111;
        lhsn_d  = alu_st ? ~oh(lhs_d) : 4'b1111;
        rhsn_d  = alu_st ? ~oh(rhs_d) : 4'b1111;
        oe_d    = (state_d == ALU_DRIVE) || (state_d == ALU_LOAD);
        gnt_d   = (state_d == X_DRIVE) || (state_d == X_LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            lhs_q   <= '0;
            rhs_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            load_q  <= 4'b0000;
            main_q  <= 4'b1111;
            lhsn_q  <= 4'b1111;
            rhsn_q  <= 4'b1111;
            oe_q    <= 1'b0;
            gnt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            lhs_q   <= lhs_d;
            rhs_q   <= rhs_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            load_q  <= load_d;
            main_q  <= main_d;
            lhsn_q  <= lhsn_d;
            rhsn_q  <= rhsn_d;
            oe_q    <= oe_d;
            gnt_q   <= gnt_d;
        end
    end

    assign req_ready   = ready_q;
    assign busy        = busy_q;
    assign gpr_load    = load_q;
    assign gpr_main_n  = main_q;
    assign gpr_lhs_n   = lhsn_q;
    assign gpr_rhs_n   = rhsn_q;
    assign alu_main_oe = oe_q;
    assign ext_gnt     = gnt_q;
endmodule
